// File: rtl/bf_exec_core_pkg.sv
// Shared definitions for the BrainHack execution core: FSM states, error
// codes and the ASCII opcode bytes of the 8-op instruction set.
package bf_exec_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_SKIP    = 3'd3,
    ST_IO_WAIT = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE            = 2'd0,
    ERR_STACK_OVERFLOW  = 2'd1,
    ERR_UNMATCHED_CLOSE = 2'd2,
    ERR_UNMATCHED_OPEN  = 2'd3
  } err_e;

  localparam logic [7:0] OP_INC   = 8'h2B;  // +
  localparam logic [7:0] OP_DEC   = 8'h2D;  // -
  localparam logic [7:0] OP_RIGHT = 8'h3E;  // >
  localparam logic [7:0] OP_LEFT  = 8'h3C;  // <
  localparam logic [7:0] OP_OPEN  = 8'h5B;  // [
  localparam logic [7:0] OP_CLOSE = 8'h5D;  // ]
  localparam logic [7:0] OP_OUT   = 8'h2E;  // .
  localparam logic [7:0] OP_IN    = 8'h2C;  // ,
  localparam logic [7:0] OP_HALT  = 8'h00;

endpackage

// File: rtl/bf_exec_core_if.sv
// Byte streams of the execution core.
//   '.' stream: o_out_valid / o_out_data (core -> env), i_out_ready (env -> core)
//   ',' stream: i_in_valid / i_in_data (env -> core), o_in_ready (core -> env)
// Signal names keep the core-relative o_/i_ prefixes so both sides read the
// same names. Modport core is the master (the execution core), env the slave.
interface bf_exec_core_if #(
  parameter int TAPE_DATA_WIDTH = 8
);

  logic                       o_out_valid;
  logic [TAPE_DATA_WIDTH-1:0] o_out_data;
  logic                       i_out_ready;
  logic                       i_in_valid;
  logic [TAPE_DATA_WIDTH-1:0] i_in_data;
  logic                       o_in_ready;

  modport core (
    output o_out_valid, o_out_data, o_in_ready,
    input  i_out_ready, i_in_valid, i_in_data
  );

  modport env (
    input  o_out_valid, o_out_data, o_in_ready,
    output i_out_ready, i_in_valid, i_in_data
  );

endinterface

// File: rtl/bf_exec_core_skip_scanner.sv
// Forward bracket scanner used while skipping a loop whose cell is zero.
// Ports:
//   i_clock, i_reset_n  clock and synchronous active-low reset
//   i_load              arm the scanner (depth <= 1), from the '[' that starts the skip
//   i_scan              one program byte is being examined this cycle
//   i_byte              the program byte at i_pc
//   i_pc                current program address
//   o_match             this byte is the ']' that closes the skipped loop
//   o_unmatched         last program address reached without a match
module bf_skip_scanner
  import bf_exec_core_pkg::*;
#(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int SKIP_DEPTH_WIDTH  = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_load,
  input  logic                         i_scan,
  input  logic [7:0]                   i_byte,
  input  logic [PRGMEM_ADDR_WIDTH-1:0] i_pc,
  output logic                         o_match,
  output logic                         o_unmatched
);

  localparam logic [SKIP_DEPTH_WIDTH-1:0] DEPTH_ONE = 1;
  localparam logic [SKIP_DEPTH_WIDTH-1:0] DEPTH_MAX = '1;
  localparam logic [PRGMEM_ADDR_WIDTH-1:0] PC_LAST  = '1;

  logic [SKIP_DEPTH_WIDTH-1:0] depth_d, depth_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    depth_d     = depth_q;
    o_match     = 1'b0;
    o_unmatched = 1'b0;
    if (i_load) begin
      depth_d = DEPTH_ONE;
    end else if (i_scan) begin
      if (i_byte == OP_OPEN) begin
        // Saturate instead of wrapping so deep nesting never fakes a match.
        if (depth_q != DEPTH_MAX) depth_d = depth_q + DEPTH_ONE;
      end else if (i_byte == OP_CLOSE) begin
        depth_d = depth_q - DEPTH_ONE;
        o_match = (depth_q == DEPTH_ONE);
      end
      o_unmatched = !o_match && (i_pc == PC_LAST);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) depth_q <= '0;
    else            depth_q <= depth_d;
  end

endmodule

// File: rtl/bf_exec_core.sv
// BrainHack execution core: fetches from an external program ROM, works on
// external tape and loop-stack RAMs (all async read, sync write) and streams
// '.' / ',' bytes over valid/ready.
// Ports:
//   i_clock, i_reset_n      clock, synchronous active-low reset
//   i_start                 run pulse, honoured in IDLE or HALT only
//   o_busy, o_halted        run status; o_error: 0 none, 1 stack overflow,
//                           2 unmatched ']', 3 unmatched '['
//   o_prgmem_addr/i_prgmem_data           program ROM (PC / instruction byte)
//   o_tape_addr/i_tape_data/o_tape_in/o_tape_data      tape RAM
//   o_stack_addr/i_stack_data/o_stack_in/o_stack_data  loop-stack RAM
//   io                      '.' and ',' byte streams
module bf_exec_core
  import bf_exec_core_pkg::*;
#(
  parameter int TAPE_DATA_WIDTH   = 8,
  parameter int TAPE_ADDR_WIDTH   = 8,
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int STACK_ADDR_WIDTH  = 4,
  parameter int SKIP_DEPTH_WIDTH  = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_halted,
  output logic [1:0]                   o_error,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  input  logic [7:0]                   i_prgmem_data,
  output logic [TAPE_ADDR_WIDTH-1:0]   o_tape_addr,
  input  logic [TAPE_DATA_WIDTH-1:0]   i_tape_data,
  output logic                         o_tape_in,
  output logic [TAPE_DATA_WIDTH-1:0]   o_tape_data,
  output logic [STACK_ADDR_WIDTH-1:0]  o_stack_addr,
  input  logic [PRGMEM_ADDR_WIDTH-1:0] i_stack_data,
  output logic                         o_stack_in,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_stack_data,
  bf_exec_core_if.core                 io
);

  localparam logic [PRGMEM_ADDR_WIDTH-1:0] PC_ONE   = 1;
  localparam logic [PRGMEM_ADDR_WIDTH-1:0] PC_LAST  = '1;
  localparam logic [TAPE_ADDR_WIDTH-1:0]   PTR_ONE  = 1;
  localparam logic [TAPE_DATA_WIDTH-1:0]   CELL_ONE = 1;
  localparam logic [STACK_ADDR_WIDTH-1:0]  SA_ONE   = 1;
  localparam logic [STACK_ADDR_WIDTH:0]    SP_ONE   = 1;
  // sp carries one extra bit so a completely full stack is representable.
  localparam logic [STACK_ADDR_WIDTH:0]    SP_FULL  = {1'b1, {STACK_ADDR_WIDTH{1'b0}}};

  state_e                       state_d, state_q;
  err_e                         err_d, err_q;
  logic [PRGMEM_ADDR_WIDTH-1:0] pc_d, pc_q;
  logic [TAPE_ADDR_WIDTH-1:0]   ptr_d, ptr_q;
  logic [STACK_ADDR_WIDTH:0]    sp_d, sp_q;
  logic [7:0]                   ir_d, ir_q;

  logic                         advance;
  logic                         cell_nz;
  logic [PRGMEM_ADDR_WIDTH-1:0] pc_inc;
  logic                         skip_load, skip_scan, skip_match, skip_unmatched;
  logic                         tape_we, stack_we;
  logic [TAPE_DATA_WIDTH-1:0]   tape_wdata;
  logic [PRGMEM_ADDR_WIDTH-1:0] stack_wdata;
  logic [STACK_ADDR_WIDTH-1:0]  stack_addr;

  assign cell_nz = (i_tape_data != '0);
  assign pc_inc  = pc_q + PC_ONE;

  bf_skip_scanner #(
    .PRGMEM_ADDR_WIDTH (PRGMEM_ADDR_WIDTH),
    .SKIP_DEPTH_WIDTH  (SKIP_DEPTH_WIDTH)
  ) u_skip (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_load      (skip_load),
    .i_scan      (skip_scan),
    .i_byte      (i_prgmem_data),
    .i_pc        (pc_q),
    .o_match     (skip_match),
    .o_unmatched (skip_unmatched)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    pc_d        = pc_q;
    ptr_d       = ptr_q;
    sp_d        = sp_q;
    ir_d        = ir_q;
    advance     = 1'b0;
    skip_load   = 1'b0;
    skip_scan   = 1'b0;
    tape_we     = 1'b0;
    tape_wdata  = '0;
    stack_we    = 1'b0;
    stack_wdata = '0;
    stack_addr  = sp_q[STACK_ADDR_WIDTH-1:0];

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (i_start) begin
          pc_d    = '0;
          ptr_d   = '0;
          sp_d    = '0;
          err_d   = ERR_NONE;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        ir_d    = i_prgmem_data;
        state_d = (i_prgmem_data == OP_HALT) ? ST_HALT : ST_EXEC;
      end

      ST_EXEC: begin
        case (ir_q)
          OP_INC: begin
            tape_we    = 1'b1;
            tape_wdata = i_tape_data + CELL_ONE;
            advance    = 1'b1;
          end
          OP_DEC: begin
            tape_we    = 1'b1;
            tape_wdata = i_tape_data - CELL_ONE;
            advance    = 1'b1;
          end
          OP_RIGHT: begin
            ptr_d   = ptr_q + PTR_ONE;
            advance = 1'b1;
          end
          OP_LEFT: begin
            ptr_d   = ptr_q - PTR_ONE;
            advance = 1'b1;
          end
          OP_OPEN: begin
            if (cell_nz) begin
              if (sp_q == SP_FULL) begin
                err_d   = ERR_STACK_OVERFLOW;
                state_d = ST_HALT;
              end else begin
                stack_we    = 1'b1;
                stack_wdata = pc_inc;
                sp_d        = sp_q + SP_ONE;
                advance     = 1'b1;
              end
            end else if (pc_q == PC_LAST) begin
              state_d = ST_HALT;  // PC would leave the program: plain halt
            end else begin
              skip_load = 1'b1;
              pc_d      = pc_inc;
              state_d   = ST_SKIP;
            end
          end
          OP_CLOSE: begin
            // Top of stack lives at sp-1; the loop re-enters without a pop.
            stack_addr = sp_q[STACK_ADDR_WIDTH-1:0] - SA_ONE;
            if (sp_q == '0) begin
              err_d   = ERR_UNMATCHED_CLOSE;
              state_d = ST_HALT;
            end else if (cell_nz) begin
              pc_d    = i_stack_data;
              state_d = ST_FETCH;
            end else begin
              sp_d    = sp_q - SP_ONE;
              advance = 1'b1;
            end
          end
          OP_OUT, OP_IN: state_d = ST_IO_WAIT;
          default:       advance = 1'b1;  // any other byte is a NOP
        endcase
      end

      ST_SKIP: begin
        skip_scan = 1'b1;
        if (skip_match) begin
          advance = 1'b1;
        end else if (skip_unmatched) begin
          err_d   = ERR_UNMATCHED_OPEN;
          state_d = ST_HALT;
        end else begin
          pc_d = pc_inc;
        end
      end

      ST_IO_WAIT: begin
        if (ir_q == OP_OUT) begin
          advance = io.i_out_ready;
        end else if (io.i_in_valid) begin
          tape_we    = 1'b1;
          tape_wdata = io.i_in_data;
          advance    = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Common "next instruction" step; running off the top address halts.
    if (advance) begin
      if (pc_q == PC_LAST) begin
        state_d = ST_HALT;
      end else begin
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end
    end
  end

  // NOTE: only control registers are reset; tape, program and stack storage
  // are external and deliberately keep their contents across reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      pc_q    <= '0;
      ptr_q   <= '0;
      sp_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      sp_q    <= sp_d;
      ir_q    <= ir_d;
    end
  end

  assign o_busy        = (state_q == ST_FETCH) || (state_q == ST_EXEC) ||
                         (state_q == ST_SKIP)  || (state_q == ST_IO_WAIT);
  assign o_halted      = (state_q == ST_HALT);
  assign o_error       = err_q;
  assign o_prgmem_addr = pc_q;
  assign o_tape_addr   = ptr_q;
  assign o_tape_in     = tape_we;
  assign o_tape_data   = tape_wdata;
  assign o_stack_addr  = stack_addr;
  assign o_stack_in    = stack_we;
  assign o_stack_data  = stack_wdata;

  // Stream handshakes come from registered state only, never from the peer's
  // valid/ready, so there is no combinational loop through the environment.
  assign io.o_out_valid = (state_q == ST_IO_WAIT) && (ir_q == OP_OUT);
  assign io.o_out_data  = io.o_out_valid ? i_tape_data : '0;
  assign io.o_in_ready  = (state_q == ST_IO_WAIT) && (ir_q == OP_IN);

endmodule

// File: tb/tb_bf_exec_core.sv
// Scoreboard bench for bf_exec_core: a behavioural BF interpreter predicts the
// output byte stream, final error code and tape; a monitor pops expected
// output bytes on each '.' handshake.
module tb_bf_exec_core;

  localparam int STACK_DEPTH = 16;
  localparam int HALT_LIMIT  = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, halted;
  logic [1:0] error;
  logic [7:0] prg_addr, prg_data, tape_addr, tape_rd, tape_wd;
  logic       tape_we, stack_we;
  logic [3:0] stack_addr;
  logic [7:0] stack_rd, stack_wd;

  bf_exec_core_if #(.TAPE_DATA_WIDTH(8)) io ();

  bf_exec_core dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_start       (start),
    .o_busy        (busy),
    .o_halted      (halted),
    .o_error       (error),
    .o_prgmem_addr (prg_addr),
    .i_prgmem_data (prg_data),
    .o_tape_addr   (tape_addr),
    .i_tape_data   (tape_rd),
    .o_tape_in     (tape_we),
    .o_tape_data   (tape_wd),
    .o_stack_addr  (stack_addr),
    .i_stack_data  (stack_rd),
    .o_stack_in    (stack_we),
    .o_stack_data  (stack_wd),
    .io            (io)
  );

  always #5 clk = ~clk;

  // Environment memories
  logic [7:0] prog      [256];
  logic [7:0] tape_mem  [256];
  logic [7:0] stack_mem [STACK_DEPTH];
  logic       clr_tape = 1'b0;

  assign prg_data = prog[prg_addr];
  assign tape_rd  = tape_mem[tape_addr];
  assign stack_rd = stack_mem[stack_addr];

  always @(posedge clk) begin
    if (clr_tape) begin
      for (int i = 0; i < 256; i++) tape_mem[i] <= 8'h00;
    end else if (tape_we) begin
      tape_mem[tape_addr] <= tape_wd;
    end
    if (stack_we) stack_mem[stack_addr] <= stack_wd;
  end

  // Reference model state
  logic [7:0] m_prog [256];
  logic [7:0] m_tape [256];
  logic [7:0] m_in_q [$];
  logic [7:0] exp_q  [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {12'd0, busy, halted, error, prg_addr, tape_addr, tape_we, tape_wd,
            stack_addr, stack_we, stack_wd, io.o_out_valid, io.o_out_data, io.o_in_ready};
  endfunction

  // Plain BF interpreter: returns the final error code, or -1 if it never halts.
  task automatic model_run(output int err);
    int         pc, ptr, d, p;
    int         st [$];
    logic [7:0] op;
    bit         step_on;
    pc  = 0;
    ptr = 0;
    err = 0;
    for (int steps = 0; steps < 100000; steps++) begin
      op      = m_prog[pc];
      step_on = 1'b1;
      if (op == 8'h00) return;
      case (op)
        "+": m_tape[ptr] = m_tape[ptr] + 8'd1;
        "-": m_tape[ptr] = m_tape[ptr] - 8'd1;
        ">": ptr = (ptr + 1) % 256;
        "<": ptr = (ptr + 255) % 256;
        ".": exp_q.push_back(m_tape[ptr]);
        ",": m_tape[ptr] = m_in_q.pop_front();
        "[": begin
          if (m_tape[ptr] != 0) begin
            if (st.size() == STACK_DEPTH) begin err = 1; return; end
            st.push_back(pc + 1);
          end else begin
            if (pc == 255) return;
            d = 1;
            for (p = pc + 1; p < 256 && d > 0; p++) begin
              if (m_prog[p] == "[") d++;
              else if (m_prog[p] == "]") d--;
            end
            if (d > 0) begin err = 3; return; end
            if (p == 256) return;
            pc      = p;
            step_on = 1'b0;
          end
        end
        "]": begin
          if (st.size() == 0) begin err = 2; return; end
          if (m_tape[ptr] != 0) begin
            pc      = st[$];
            step_on = 1'b0;
          end else begin
            void'(st.pop_back());
          end
        end
        default: ;
      endcase
      if (step_on) begin
        if (pc == 255) return;
        pc++;
      end
    end
    err = -1;
  endtask

  // Stream environment knobs
  logic [7:0] drv_in_q [$];
  logic [7:0] pend_in  [$];
  int  rdy_pct    = 100;
  int  stall_left = 0;
  int  gap_max    = 0;
  int  gap_left   = 0;
  bit  in_hs      = 1'b0;

  // '.' ready driver: forced stall cycles first, then random readiness.
  always @(posedge clk) begin
    #1;
    if (io.o_out_valid && stall_left > 0) begin
      io.i_out_ready = 1'b0;
      stall_left--;
    end else begin
      io.i_out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // ',' valid driver: waits gap_left ready cycles, then holds valid until taken.
  always @(negedge clk) begin
    if (in_hs) begin
      void'(drv_in_q.pop_front());
      io.i_in_valid = 1'b0;
      gap_left = $urandom_range(0, gap_max);
    end
    in_hs = 1'b0;
    if (!io.i_in_valid && drv_in_q.size() > 0 && io.o_in_ready) begin
      if (gap_left > 0) gap_left--;
      else begin
        io.i_in_valid = 1'b1;
        io.i_in_data  = drv_in_q[0];
      end
    end
    if (io.i_in_valid && io.o_in_ready) in_hs = 1'b1;
  end

  // Output monitor: compares every '.' beat and stall stability.
  logic [7:0] held_data;
  bit         was_stalled = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      was_stalled = 1'b0;
    end else if (io.o_out_valid) begin
      if (was_stalled) check("out_stable", io.o_out_data, held_data);
      if (io.i_out_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", io.o_out_data, 64'hFFFF_FFFF);
        else                   check("out_data", io.o_out_data, exp_q.pop_front());
        was_stalled = 1'b0;
      end else begin
        was_stalled = 1'b1;
        held_data   = io.o_out_data;
      end
    end else if (was_stalled) begin
      check("out_valid_held", io.o_out_valid, 1);
      was_stalled = 1'b0;
    end
  end

  task automatic load_prog(input string p);
    for (int i = 0; i < 256; i++) begin
      prog[i]   = (i < p.len()) ? p[i] : 8'h00;
      m_prog[i] = prog[i];
    end
  endtask

  task automatic clear_tape();
    @(negedge clk) clr_tape = 1'b1;
    @(negedge clk) clr_tape = 1'b0;
    for (int i = 0; i < 256; i++) m_tape[i] = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_prog(input string name, input string p, input int gmax,
                          input int rpct, input int stall, output int cycles);
    int err, mism;
    load_prog(p);
    m_in_q   = pend_in;
    drv_in_q = pend_in;
    model_run(err);
    gap_max    = gmax;
    gap_left   = gmax;
    rdy_pct    = rpct;
    stall_left = stall;
    pulse_start();
    cycles = 0;
    while (!halted && cycles < HALT_LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_halted"}, halted, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_error"}, error, err[1:0]);
    check({name, "_outs_left"}, exp_q.size(), 0);
    exp_q.delete();
    mism = 0;
    for (int i = 0; i < 256; i++) if (tape_mem[i] !== m_tape[i]) mism++;
    check({name, "_tape_mismatches"}, mism, 0);
  endtask

  initial begin
    int    cyc, err, nf, k;
    string s;
    string frags [10] = '{"+", "+", "-", ">", "<", ".", ",", "z", "[-]", "[>+<-]"};

    rst_n = 1'b0;
    start = 1'b0;
    io.i_out_ready = 1'b0;
    io.i_in_valid  = 1'b0;
    io.i_in_data   = 8'h00;
    for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] = 8'h00;
    load_prog("");
    clear_tape();
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;

    // 1: 3 increments + output, 2 cycles per instr, 1 extra for I/O, 1 halt fetch
    run_prog("t1", "+++.", 0, 100, 0, cyc);
    check("t1_cycles", cyc, 10);
    check("t1_tape0", tape_mem[0], 8'h03);

    // 2: simple move loop
    clear_tape();
    run_prog("t2", "++[>+<-]>.", 0, 100, 0, cyc);
    check("t2_tape0", tape_mem[0], 8'h00);
    check("t2_tape1", tape_mem[1], 8'h02);

    // 3: nested forward skip, then unmatched '['
    clear_tape();
    run_prog("t3a", "[[+]]+.", 0, 100, 0, cyc);
    clear_tape();
    run_prog("t3b", "[+", 0, 100, 0, cyc);
    check("t3b_err3", error, 2'd3);

    // 4: late input, stalled output
    clear_tape();
    pend_in = '{8'h41};
    run_prog("t4", ",+.", 5, 100, 3, cyc);
    pend_in.delete();

    // 5: stack overflow on the 17th nested '[' and unmatched ']'
    s = "+";
    for (int i = 0; i < STACK_DEPTH + 1; i++) s = {s, "["};
    run_prog("t5a", s, 0, 100, 0, cyc);
    check("t5a_err1", error, 2'd1);
    run_prog("t5b", "]", 0, 100, 0, cyc);
    check("t5b_err2", error, 2'd2);
    clear_tape();
    run_prog("t5c", "<-.", 0, 70, 0, cyc);
    check("t5c_ptr_wrap", tape_addr, 8'hFF);

    // 6: reset while '.' is stalled; tape survives, restart runs from pc 0
    clear_tape();
    load_prog("+>++.");
    model_run(err);
    exp_q.delete();
    stall_left = 1000;
    pulse_start();
    cyc = 0;
    while (!io.o_out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_out_valid", io.o_out_valid, 1);
    check("t6_out_data", io.o_out_data, 8'h02);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_left = 0;
    run_prog("t6r", ".>.", 0, 100, 0, cyc);

    // 7: random programs with random stream back-pressure
    for (int r = 0; r < 12; r++) begin
      s  = "";
      nf = $urandom_range(3, 12);
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 29) == 0) s = {s, "]"};
        else begin
          k = $urandom_range(0, 9);
          s = {s, frags[k]};
        end
      end
      pend_in.delete();
      for (int i = 0; i < s.len(); i++)
        if (s[i] == ",") pend_in.push_back(8'($urandom_range(0, 255)));
      run_prog("rnd", s, 3, $urandom_range(40, 100), $urandom_range(0, 2), cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
